// File: rtl/ifu_fetch_64.sv
// Instruction fetch unit: sequential PC generator feeding a 2-entry {PC, INST} queue toward decode.
// Optional macro IFU_MISALIGN_CHK_EN: a misaligned redirect halts fetch and raises a sticky error.
module ifu_fetch_64 #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [63:0] PC,
    input  logic [31:0] INST_CODE,
    input  logic        REDIRECT,
    input  logic [63:0] REDIRECT_PC,
    input  logic        ID_READY,
    output logic        ID_VALID,
    output logic [31:0] ID_INST,
    output logic [63:0] ID_PC,
    output logic        MISALIGN_ERR
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_reg;
    logic [63:0] pc_reg;
    logic [1:0]  count_reg;
    logic [1:0]  count_next;
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [63:0] entry_pc_reg   [2];
    logic [31:0] entry_inst_reg [2];

    logic        pop;
    logic        push;
    logic        redirect_bad;
    logic [63:0] redirect_target;

`ifdef IFU_MISALIGN_CHK_EN
    logic misalign_reg;

    assign redirect_bad    = REDIRECT && (REDIRECT_PC[1:0] != 2'b00);
    assign redirect_target = REDIRECT_PC;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            misalign_reg <= 1'b0;
        end else if (state_reg == RUN && redirect_bad) begin
            misalign_reg <= 1'b1;
        end
    end

    assign MISALIGN_ERR = misalign_reg;
`else
    logic unused_redirect_lsb;

    // Low bits are simply dropped so the fetch stream stays word aligned.
    assign redirect_bad        = 1'b0;
    assign redirect_target     = {REDIRECT_PC[63:2], 2'b00};
    assign unused_redirect_lsb = ^REDIRECT_PC[1:0];
    assign MISALIGN_ERR        = 1'b0;
`endif

    assign ID_VALID = (count_reg != 2'd0);
    assign pop      = ID_VALID && ID_READY;
    // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
    assign push     = (state_reg == RUN) && !REDIRECT && ((count_reg != 2'd2) || pop);

    always_comb begin
        count_next = count_reg + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= RUN;
            pc_reg     <= RESET_PC;
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (REDIRECT) begin
                        // Redirect flushes the queue; a same-cycle pop is dropped with it.
                        count_reg  <= 2'd0;
                        rd_ptr_reg <= 1'b0;
                        wr_ptr_reg <= 1'b0;
                        if (redirect_bad) begin
                            state_reg <= HALT;
                        end else begin
                            pc_reg <= redirect_target;
                        end
                    end else begin
                        if (push) begin
                            pc_reg     <= pc_reg + PC_STEP;
                            wr_ptr_reg <= ~wr_ptr_reg;
                        end
                        if (pop) begin
                            rd_ptr_reg <= ~rd_ptr_reg;
                        end
                        count_reg <= count_next;
                    end
                end
                HALT: begin
                    count_reg <= 2'd0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    entry_pc_reg[gi]   <= 64'd0;
                    entry_inst_reg[gi] <= 32'd0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_pc_reg[gi]   <= pc_reg;
                    entry_inst_reg[gi] <= INST_CODE;
                end
            end
        end
    endgenerate

    assign PC      = pc_reg;
    assign ID_INST = ID_VALID ? entry_inst_reg[rd_ptr_reg] : 32'd0;
    assign ID_PC   = ID_VALID ? entry_pc_reg[rd_ptr_reg]   : 64'd0;

endmodule

// File: doc/ifu_fetch_64.md
IFU_FETCH_64 -- requirements
Module: ifu_fetch_64

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 The block SHALL provide parameter PC_STEP, default 64'd4, sequential PC increment.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port PC  output  64  fetch address to instruction memory.
REQ-006 The block SHALL have port INST_CODE  input  32  instruction returned combinationally by instruction memory for the current PC.
REQ-007 The block SHALL have port REDIRECT  input  1  branch/jump taken; load REDIRECT_PC.
REQ-008 The block SHALL have port REDIRECT_PC  input  64  redirect target address.
REQ-009 The block SHALL have port ID_READY  input  1  decode accepts the head entry this cycle.
REQ-010 The block SHALL have port ID_VALID  output  1  queue head valid.
REQ-011 The block SHALL have port ID_INST  output  32  instruction at queue head.
REQ-012 The block SHALL have port ID_PC  output  64  PC of the instruction at queue head.
REQ-013 The block SHALL have port MISALIGN_ERR  output  1  sticky misaligned-redirect flag.

Function
REQ-014 The block SHALL hold a 2-entry FIFO of {PC, INST_CODE} pairs with a count of 0..2.
REQ-015 The block SHALL implement FSM states RUN and HALT; the block resets into RUN.
REQ-016 In RUN with no REDIRECT, when count<2 or a pop occurs this cycle, the block SHALL push {PC, INST_CODE} and update PC <= PC+PC_STEP, modulo 2^64.
REQ-017 The block SHALL wrap PC 64'hFFFF_FFFF_FFFF_FFFC + 4 to 64'h0 without flagging an error.
REQ-018 The block SHALL hold PC and push nothing when count==2 and no pop occurs.
REQ-019 ID_VALID SHALL equal (count!=0); a pop SHALL occur iff ID_VALID && ID_READY.
REQ-020 When the FIFO is empty, ID_INST and ID_PC SHALL be 0.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-022 A fetched instruction SHALL appear at ID_INST one cycle after fetch when the FIFO was empty.
REQ-023 REDIRECT SHALL take priority over push and pop: count <= 0, PC <= REDIRECT_PC, no push that cycle, and any pop that cycle is discarded.
REQ-024 Fetch from REDIRECT_PC SHALL begin on the cycle after REDIRECT, with ID_VALID=1 from the following cycle.
REQ-025 In HALT, the block SHALL hold PC, push nothing, keep count=0 and ID_VALID=0, and ignore REDIRECT; only RESET leaves HALT.

Reset
REQ-026 When RESET=1 at a rising edge, the block SHALL set PC=RESET_PC, count=0, ID_VALID=0, ID_INST=0, ID_PC=0, MISALIGN_ERR=0 and state=RUN.
REQ-027 RESET SHALL override REDIRECT and fetch in the same cycle; INST_CODE SHALL be ignored during reset.
REQ-028 A RESET asserted mid-operation SHALL discard all queued entries with no partial pop.

Configuration
REQ-029 With macro IFU_MISALIGN_CHK_EN defined, a REDIRECT with REDIRECT_PC[1:0]!=2'b00 SHALL flush the FIFO, set MISALIGN_ERR=1 and enter HALT, leaving PC unchanged.
REQ-030 Without IFU_MISALIGN_CHK_EN, the block SHALL load REDIRECT_PC with bits [1:0] forced to 2'b00 and tie MISALIGN_ERR to 0.

Verification
REQ-031 Release RESET, ID_READY=1, memory returns word n at PC=4n -> ID_PC sequence 0,4,8,12 on consecutive cycles, ID_VALID=1 from the 2nd cycle.
REQ-032 Hold ID_READY=0 for 5 cycles -> count saturates at 2, PC holds at 8, ID_INST=word 0; raise ID_READY -> words 0,1,2 drain in order with no gaps.
REQ-033 REDIRECT=1, REDIRECT_PC=64'h100 while count=2 -> next cycle ID_VALID=0 and PC=64'h100; the cycle after, ID_PC=64'h100.
REQ-034 Start with RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> ID_PC sequence FFF8, FFFC, 0, 4 with MISALIGN_ERR=0.
REQ-035 With IFU_MISALIGN_CHK_EN, REDIRECT_PC=64'h102 -> MISALIGN_ERR=1 and ID_VALID=0, PC frozen even under a later aligned REDIRECT, cleared only by RESET; without the macro, PC becomes 64'h100.
